// File: rtl/fetch_sequencer.sv
// fetch_sequencer
// Holds the fetch PC and runs a single-outstanding req/ack fetch to a
// variable-latency instruction memory. Returned words go into a 2-entry
// queue whose head feeds decode. Redirects flush the queue. A fetch that is
// in flight when the redirect arrives is drained, and its data is dropped.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no request on the bus; waiting for queue space or a redirect
// REQ   | request to fetch_pc outstanding; data is kept on ack
// DRAIN | stale request outstanding; data is dropped, redir_pc is next
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned PC_STEP   = 4,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] fetch_pc;
    logic [31:0] redir_pc;

    // Two-entry fetch queue. q0 is always the head.
    logic [1:0]  count;
    logic [31:0] q0_pc;
    logic [31:0] q0_instr;
    logic [31:0] q1_pc;
    logic [31:0] q1_instr;

    logic        flush;
    logic        push;
    logic        pop;
    logic [1:0]  count_after_pop;
    logic [1:0]  count_next;
    logic        room_next;

    assign imem_addr = fetch_pc;

    assign if_valid  = (count != 2'd0);
    assign if_pc     = if_valid ? q0_pc : 32'h0000_0000;
    assign if_instr  = if_valid ? q0_instr : NOP_INSTR;

    // Queue control: a redirect wins over both push and pop.
    always_comb begin
        flush           = redirect_valid;
        push            = (state == REQ) && imem_ack && !redirect_valid;
        pop             = if_valid && !stall;
        count_after_pop = count - {1'b0, pop};
        if (flush) begin
            count_next = 2'd0;
        end else begin
            count_next = count_after_pop + {1'b0, push};
        end
        // One free slot after this cycle is enough for another request,
        // which keeps count + outstanding within the two queue slots.
        room_next = (count_next < 2'd2);
    end

    // Queue storage: shift on pop, write the first free slot on push.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count    <= 2'd0;
            q0_pc    <= 32'h0000_0000;
            q0_instr <= NOP_INSTR;
            q1_pc    <= 32'h0000_0000;
            q1_instr <= NOP_INSTR;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            count <= count_next;
            if (pop) begin
                q0_pc    <= q1_pc;
                q0_instr <= q1_instr;
            end
            // Later assignment wins, so a push into an emptied head
            // overrides the shift above.
            if (push) begin
                if (count_after_pop == 2'd0) begin
                    q0_pc    <= fetch_pc;
                    q0_instr <= imem_rdata;
                end else begin
                    q1_pc    <= fetch_pc;
                    q1_instr <= imem_rdata;
                end
            end
        end
    end

    // Fetch FSM: tracks the outstanding request, the fetch PC and redirects.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            imem_req <= 1'b0;
            fetch_pc <= RESET_PC;
            redir_pc <= RESET_PC;
        end else begin
            case (state)
                IDLE: begin
                    if (redirect_valid) begin
                        fetch_pc <= redirect_pc;
                        state    <= REQ;
                        imem_req <= 1'b1;
                    end else if (room_next) begin
                        state    <= REQ;
                        imem_req <= 1'b1;
                    end
                end
                REQ: begin
                    if (imem_ack) begin
                        if (redirect_valid) begin
                            // The returning word is already stale.
                            fetch_pc <= redirect_pc;
                        end else begin
                            fetch_pc <= fetch_pc + 32'(PC_STEP);
                            if (!room_next) begin
                                state    <= IDLE;
                                imem_req <= 1'b0;
                            end
                        end
                    end else if (redirect_valid) begin
                        // The address must stay put until the memory acks,
                        // so park the target and drop the data later.
                        redir_pc <= redirect_pc;
                        state    <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (imem_ack) begin
                        fetch_pc <= redirect_valid ? redirect_pc : redir_pc;
                        state    <= REQ;
                    end else if (redirect_valid) begin
                        redir_pc <= redirect_pc;
                    end
                end
                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer. A queue-level reference model is
// checked against the DUT on every falling edge, and literal expectations
// at key points pin the model itself.
module tb_fetch_sequencer;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    always #5 clk = ~clk;

    fetch_sequencer #(
        .RESET_PC (RESET_PC),
        .PC_STEP  (4),
        .NOP_INSTR(NOP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .stall         (stall),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .if_valid      (if_valid),
        .if_pc         (if_pc),
        .if_instr      (if_instr)
    );

    // Memory contents are a fixed function of the address.
    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    assign imem_rdata = memf(imem_addr);

    int vectors = 0;
    int errors  = 0;

    // Reference model: request line, current fetch address, whether the
    // outstanding request is stale, where to go after it, and the queue.
    logic        m_req;
    logic [31:0] m_addr;
    logic        m_discard;
    logic [31:0] m_target;
    logic [63:0] mq[$];
    logic [31:0] e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_req     = 1'b0;
        m_addr    = RESET_PC;
        m_discard = 1'b0;
        m_target  = 32'h0;
        mq.delete();
    endtask

    task automatic model_step();
        bit pop;
        bit xfer;
        pop  = (mq.size() != 0) && !stall;
        xfer = m_req && imem_ack;
        if (redirect_valid) begin
            mq.delete();
            if (!m_req || xfer) begin
                m_addr    = redirect_pc;
                m_req     = 1'b1;
                m_discard = 1'b0;
            end else begin
                m_discard = 1'b1;
                m_target  = redirect_pc;
            end
        end else begin
            if (pop) void'(mq.pop_front());
            if (xfer) begin
                if (m_discard) begin
                    m_addr    = m_target;
                    m_discard = 1'b0;
                end else begin
                    mq.push_back({m_addr, memf(m_addr)});
                    m_addr = m_addr + 32'd4;
                    m_req  = (mq.size() <= 1);
                end
            end else if (!m_req) begin
                m_req = (mq.size() <= 1);
            end
        end
    endtask

    // One clock cycle with the given inputs; the model advances on the edge.
    task automatic cyc(input logic rv, input logic [31:0] rp, input logic st, input logic ak);
        redirect_valid = rv;
        redirect_pc    = rp;
        stall          = st;
        imem_ack       = ak;
        @(posedge clk);
        if (rst) model_step();
        else model_reset();
        #1;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_req"},   {31'b0, imem_req}, 32'h0);
        chk({tag, "_addr"},  imem_addr, RESET_PC);
        chk({tag, "_valid"}, {31'b0, if_valid}, 32'h0);
        chk({tag, "_pc"},    if_pc, 32'h0);
        chk({tag, "_instr"}, if_instr, NOP);
    endtask

    // Every-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        e_valid = (mq.size() != 0) ? 32'h1 : 32'h0;
        e_pc    = (mq.size() != 0) ? mq[0][63:32] : 32'h0;
        e_instr = (mq.size() != 0) ? mq[0][31:0] : NOP;
        chk("imem_req",  {31'b0, imem_req}, {31'b0, m_req});
        chk("imem_addr", imem_addr, m_addr);
        chk("if_valid",  {31'b0, if_valid}, e_valid);
        chk("if_pc",     if_pc, e_pc);
        chk("if_instr",  if_instr, e_instr);
    end

    initial begin
        rst            = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        stall          = 1'b0;
        imem_ack       = 1'b0;
        model_reset();
        #2;
        chk_reset_values("rst0");
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Back-to-back acks, no stall.
        cyc(1'b0, 32'h0, 1'b0, 1'b1);
        chk("t1_first_req",  {31'b0, imem_req}, 32'h1);
        chk("t1_first_addr", imem_addr, 32'h0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 32'h0, 1'b0, 1'b1);
        chk("t1_addr",  imem_addr, 32'h14);
        chk("t1_pc",    if_pc, 32'h10);
        chk("t1_instr", if_instr, memf(32'h10));

        // Stall fills the queue and drops req; release resumes at the next PC.
        cyc(1'b0, 32'h0, 1'b1, 1'b1);
        cyc(1'b0, 32'h0, 1'b1, 1'b1);
        chk("t2_full_req",  {31'b0, imem_req}, 32'h0);
        chk("t2_full_addr", imem_addr, 32'h18);
        chk("t2_full_pc",   if_pc, 32'h10);
        cyc(1'b0, 32'h0, 1'b0, 1'b1);
        chk("t2_rel_req",  {31'b0, imem_req}, 32'h1);
        chk("t2_rel_addr", imem_addr, 32'h18);
        chk("t2_rel_pc",   if_pc, 32'h14);
        cyc(1'b0, 32'h0, 1'b0, 1'b1);
        chk("t2_next_pc",   if_pc, 32'h18);
        chk("t2_next_addr", imem_addr, 32'h1C);

        // Slow memory: address held, queue drains, data one cycle after ack.
        for (int i = 0; i < 3; i++) cyc(1'b0, 32'h0, 1'b0, 1'b0);
        chk("t3_wait_req",   {31'b0, imem_req}, 32'h1);
        chk("t3_wait_addr",  imem_addr, 32'h1C);
        chk("t3_wait_valid", {31'b0, if_valid}, 32'h0);
        cyc(1'b0, 32'h0, 1'b0, 1'b1);
        chk("t3_ack_valid", {31'b0, if_valid}, 32'h1);
        chk("t3_ack_pc",    if_pc, 32'h1C);

        // Redirect while a fetch is pending: its data must never appear.
        cyc(1'b1, 32'h100, 1'b0, 1'b0);
        chk("t4_drain_valid", {31'b0, if_valid}, 32'h0);
        chk("t4_drain_addr",  imem_addr, 32'h20);
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 1'b1);
        chk("t4_new_addr",  imem_addr, 32'h100);
        chk("t4_new_valid", {31'b0, if_valid}, 32'h0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
        chk("t4_stale_valid", {31'b0, if_valid}, 32'h0);
        cyc(1'b1, 32'h180, 1'b0, 1'b0);
        cyc(1'b1, 32'h1C0, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 1'b1);
        chk("t4_latest_addr", imem_addr, 32'h1C0);
        cyc(1'b0, 32'h0, 1'b0, 1'b1);

        // Redirect with ack and stall; then redirect into a full queue.
        cyc(1'b1, 32'h200, 1'b1, 1'b1);
        chk("t5_ack_valid", {31'b0, if_valid}, 32'h0);
        chk("t5_ack_addr",  imem_addr, 32'h200);
        cyc(1'b0, 32'h0, 1'b1, 1'b1);
        cyc(1'b0, 32'h0, 1'b1, 1'b1);
        chk("t5_full_req", {31'b0, imem_req}, 32'h0);
        chk("t5_full_pc",  if_pc, 32'h200);
        cyc(1'b1, 32'h300, 1'b1, 1'b1);
        chk("t5_flush_valid", {31'b0, if_valid}, 32'h0);
        chk("t5_flush_addr",  imem_addr, 32'h300);
        chk("t5_flush_req",   {31'b0, imem_req}, 32'h1);
        cyc(1'b0, 32'h0, 1'b0, 1'b1);

        // Drain finishing on the same cycle as a newer redirect.
        cyc(1'b1, 32'h400, 1'b0, 1'b0);
        cyc(1'b1, 32'h500, 1'b0, 1'b1);
        chk("t5_drain_redir_addr", imem_addr, 32'h500);
        cyc(1'b1, 32'h600, 1'b0, 1'b0);
        chk("t6_drain_addr", imem_addr, 32'h500);

        // Asynchronous reset while draining.
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        chk_reset_values("t6_async");
        cyc(1'b0, 32'h0, 1'b0, 1'b1);
        cyc(1'b0, 32'h0, 1'b0, 1'b1);
        rst = 1'b1;
        cyc(1'b0, 32'h0, 1'b0, 1'b1);
        chk("t6_restart_req",  {31'b0, imem_req}, 32'h1);
        chk("t6_restart_addr", imem_addr, RESET_PC);
        cyc(1'b0, 32'h0, 1'b0, 1'b1);

        // Mixed traffic covered by the model.
        for (int i = 0; i < 60; i++) begin
            cyc((i % 11) == 7, 32'h1000 + 32'(i * 16),
                ((i % 5) == 2) || ((i % 7) == 3), (i % 3) != 1);
        end
        cyc(1'b0, 32'h0, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
